// File: rtl/pcs_bip_pkg.sv
// Shared constants and arithmetic helpers for the PCS BIP error monitor.
// Helpers work on a fixed 64-bit container; callers size-cast in and out.
package pcs_bip_pkg;

  localparam int N_LANES_DEF = 20;
  localparam int NB_BIP_DEF  = 8;
  localparam int SAT_W       = 64;

  function automatic int unsigned popcount(input logic [SAT_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < SAT_W; i++) n = n + {31'b0, v[i]};
    return n;
  endfunction

  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input logic [SAT_W-1:0] max_v);
    logic [SAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_v}) ? max_v : sum[SAT_W-1:0];
  endfunction

  function automatic logic add_ovf(input logic [SAT_W-1:0] a,
                                   input logic [SAT_W-1:0] b,
                                   input logic [SAT_W-1:0] max_v);
    logic [SAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum > {1'b0, max_v};
  endfunction

endpackage

// File: rtl/bip_lane_counter.sv
// One PCS lane: BIP mismatch popcount, saturating total counter with sticky
// saturation flag, and the windowed error-rate alarm.
module bip_lane_counter
  import pcs_bip_pkg::*;
#(
  parameter int NB_BIP     = NB_BIP_DEF,
  parameter int NB_COUNTER = 32,
  parameter int NB_WINDOW  = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_accept,
  input  logic [NB_BIP-1:0]     i_recv_bip,
  input  logic [NB_BIP-1:0]     i_calc_bip,
  input  logic                  i_clear,
  input  logic                  i_rd_clear,
  input  logic [NB_WINDOW-1:0]  i_window_len,
  input  logic [NB_WINDOW-1:0]  i_err_threshold,
  output logic [NB_COUNTER-1:0] o_count,
  output logic                  o_sat,
  output logic                  o_alarm
);

  localparam int NB_POP = $clog2(NB_BIP + 1);
  localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({NB_COUNTER{1'b1}});
  localparam logic [SAT_W-1:0] WIN_MAX = SAT_W'({NB_WINDOW{1'b1}});

  logic [NB_POP-1:0]     pop;
  logic [NB_COUNTER-1:0] cnt_base;
  logic [NB_COUNTER-1:0] cnt_next;
  logic                  cnt_ovf;
  logic [NB_WINDOW-1:0]  win_next;
  logic                  win_last;

  logic [NB_COUNTER-1:0] cnt_p1;
  logic                  sat_p1;
  logic [NB_WINDOW-1:0]  win_cnt_p1;
  logic [NB_WINDOW-1:0]  win_err_p1;
  logic                  alarm_p1;

  // A clear-on-read restarts the sum from zero so a same-cycle event is kept.
  always_comb begin
    pop      = NB_POP'(popcount(SAT_W'(i_recv_bip ^ i_calc_bip)));
    cnt_base = i_rd_clear ? '0 : cnt_p1;
    cnt_next = NB_COUNTER'(sat_add(SAT_W'(cnt_base), SAT_W'(pop), CNT_MAX));
    cnt_ovf  = add_ovf(SAT_W'(cnt_base), SAT_W'(pop), CNT_MAX);
    win_next = NB_WINDOW'(sat_add(SAT_W'(win_err_p1), SAT_W'(pop), WIN_MAX));
    win_last = win_cnt_p1 >= (i_window_len - NB_WINDOW'(1));
  end

  // ---- stage p1: lane state ----
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      cnt_p1     <= '0;
      sat_p1     <= 1'b0;
      win_cnt_p1 <= '0;
      win_err_p1 <= '0;
      alarm_p1   <= 1'b0;
    end else begin
      if (i_rd_clear) begin
        cnt_p1 <= i_accept ? cnt_next : '0;
        sat_p1 <= i_accept & cnt_ovf;
      end else if (i_accept) begin
        cnt_p1 <= cnt_next;
        sat_p1 <= sat_p1 | cnt_ovf;
      end

      if (i_window_len == '0) begin
        win_cnt_p1 <= '0;
        win_err_p1 <= '0;
        alarm_p1   <= 1'b0;
      end else if (i_accept) begin
        if (win_last) begin
          alarm_p1   <= win_next >= i_err_threshold;
          win_cnt_p1 <= '0;
          win_err_p1 <= '0;
        end else begin
          win_cnt_p1 <= win_cnt_p1 + NB_WINDOW'(1);
          win_err_p1 <= win_next;
        end
      end
    end
  end

  assign o_count = cnt_p1;
  assign o_sat   = sat_p1;
  assign o_alarm = alarm_p1;

endmodule

// File: rtl/bip_error_monitor.sv
// Multi-lane BIP error monitor: per-lane counters and alarms behind a
// registered, lane-indexed read port with optional clear-on-read.
module bip_error_monitor
  import pcs_bip_pkg::*;
#(
  parameter int N_LANES    = N_LANES_DEF,
  parameter int NB_BIP     = NB_BIP_DEF,
  parameter int NB_COUNTER = 32,
  parameter int NB_WINDOW  = 8,
  localparam int NB_LANE   = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic [N_LANES-1:0]          i_am_valid,
  input  logic [N_LANES*NB_BIP-1:0]   i_recv_bip,
  input  logic [N_LANES*NB_BIP-1:0]   i_calc_bip,
  input  logic                        i_clear,
  input  logic [NB_WINDOW-1:0]        i_window_len,
  input  logic [NB_WINDOW-1:0]        i_err_threshold,
  input  logic                        i_rd_req,
  input  logic [NB_LANE-1:0]          i_rd_lane,
  input  logic                        i_rd_clear,
  output logic                        o_rd_valid,
  output logic [NB_COUNTER-1:0]       o_rd_data,
  output logic                        o_rd_sat,
  output logic                        o_rd_err,
  output logic [N_LANES-1:0]          o_alarm
);

  localparam logic [NB_LANE:0] LANE_LIMIT = (NB_LANE + 1)'(N_LANES);

  logic [NB_COUNTER-1:0] lane_count [N_LANES];
  logic [N_LANES-1:0]    lane_sat;
  logic [N_LANES-1:0]    lane_accept;
  logic [N_LANES-1:0]    lane_rd_clear;

  logic [NB_COUNTER-1:0] rd_cnt_sel;
  logic                  rd_sat_sel;
  logic                  rd_in_range;

  logic                  rd_vld_p1;
  logic [NB_COUNTER-1:0] rd_data_p1;
  logic                  rd_sat_p1;
  logic                  rd_err_p1;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    assign lane_accept[k]   = i_enable & i_am_valid[k] & ~i_clear;
    assign lane_rd_clear[k] = i_rd_req & i_rd_clear & ~i_clear &
                              (i_rd_lane == NB_LANE'(k));

    bip_lane_counter #(
      .NB_BIP     (NB_BIP),
      .NB_COUNTER (NB_COUNTER),
      .NB_WINDOW  (NB_WINDOW)
    ) u_lane (
      .i_clock         (i_clock),
      .i_reset         (i_reset),
      .i_accept        (lane_accept[k]),
      .i_recv_bip      (i_recv_bip[k*NB_BIP +: NB_BIP]),
      .i_calc_bip      (i_calc_bip[k*NB_BIP +: NB_BIP]),
      .i_clear         (i_clear),
      .i_rd_clear      (lane_rd_clear[k]),
      .i_window_len    (i_window_len),
      .i_err_threshold (i_err_threshold),
      .o_count         (lane_count[k]),
      .o_sat           (lane_sat[k]),
      .o_alarm         (o_alarm[k])
    );
  end

  // Out-of-range lanes match no slot, so the mux falls through to zero.
  always_comb begin
    rd_cnt_sel = '0;
    rd_sat_sel = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      if (i_rd_lane == NB_LANE'(k)) begin
        rd_cnt_sel = lane_count[k];
        rd_sat_sel = lane_sat[k];
      end
    end
    rd_in_range = {1'b0, i_rd_lane} < LANE_LIMIT;
  end

  // ---- stage p1: registered read port ----
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rd_vld_p1  <= 1'b0;
      rd_err_p1  <= 1'b0;
      rd_data_p1 <= '0;
      rd_sat_p1  <= 1'b0;
    end else begin
      rd_vld_p1  <= i_rd_req;
      rd_err_p1  <= i_rd_req & ~rd_in_range;
      rd_data_p1 <= i_rd_req ? rd_cnt_sel : '0;
      rd_sat_p1  <= i_rd_req & rd_sat_sel;
    end
  end

  assign o_rd_valid = rd_vld_p1;
  assign o_rd_data  = rd_data_p1;
  assign o_rd_sat   = rd_sat_p1;
  assign o_rd_err   = rd_err_p1;

endmodule

// File: tb/tb_bip_error_monitor.sv
// Scoreboard bench for bip_error_monitor: a 32-bit-counter and a 4-bit-counter
// instance share stimulus; a reference model predicts every read response.
module tb_bip_error_monitor;

  localparam int NL = 20;
  localparam int NB = 8;
  localparam longint unsigned MAX32 = 64'hFFFF_FFFF;
  localparam longint unsigned MAX4  = 64'd15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en, clr, rd_req, rd_clear;
  logic [NL-1:0]     am;
  logic [NL*NB-1:0]  recv, calc;
  logic [7:0]        wlen, thr;
  logic [4:0]        rd_lane;

  logic              vld_a, sat_a, err_a, vld_b, sat_b, err_b;
  logic [31:0]       data_a;
  logic [3:0]        data_b;
  logic [NL-1:0]     alarm_a, alarm_b;

  bip_error_monitor #(.N_LANES(NL), .NB_BIP(NB), .NB_COUNTER(32), .NB_WINDOW(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_am_valid(am),
    .i_recv_bip(recv), .i_calc_bip(calc), .i_clear(clr),
    .i_window_len(wlen), .i_err_threshold(thr),
    .i_rd_req(rd_req), .i_rd_lane(rd_lane), .i_rd_clear(rd_clear),
    .o_rd_valid(vld_a), .o_rd_data(data_a), .o_rd_sat(sat_a), .o_rd_err(err_a),
    .o_alarm(alarm_a));

  bip_error_monitor #(.N_LANES(NL), .NB_BIP(NB), .NB_COUNTER(4), .NB_WINDOW(8)) dut4 (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_am_valid(am),
    .i_recv_bip(recv), .i_calc_bip(calc), .i_clear(clr),
    .i_window_len(wlen), .i_err_threshold(thr),
    .i_rd_req(rd_req), .i_rd_lane(rd_lane), .i_rd_clear(rd_clear),
    .o_rd_valid(vld_b), .o_rd_data(data_b), .o_rd_sat(sat_b), .o_rd_err(err_b),
    .o_alarm(alarm_b));

  typedef struct {
    int          due;
    logic [31:0] d32;
    logic        s32;
    logic [3:0]  d4;
    logic        s4;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  longint unsigned m32 [NL];
  longint unsigned m4  [NL];
  bit              s32 [NL];
  bit              s4  [NL];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic set_lane(input int k, input logic [7:0] r, input logic [7:0] c);
    recv[k*NB +: NB] = r;
    calc[k*NB +: NB] = c;
  endtask

  function automatic logic [7:0] ones(input int p);
    logic [8:0] v;
    v = (9'd1 << p) - 9'd1;
    return v[7:0];
  endfunction

  // Drive one cycle of stimulus, queue the expected read response and advance the model.
  task automatic step(input logic [NL-1:0] am_m, input logic rq = 1'b0,
                      input logic [4:0] ln = '0, input logic rc = 1'b0,
                      input logic cl = 1'b0);
    exp_t e;
    int unsigned pop;
    bit acc;
    longint unsigned s;
    am = am_m; rd_req = rq; rd_lane = ln; rd_clear = rc; clr = cl;
    if (rq) begin
      e.due = cyc + 1;
      e.err = (ln >= NL);
      if (ln < NL) begin
        e.d32 = m32[ln][31:0]; e.s32 = s32[ln];
        e.d4  = m4[ln][3:0];   e.s4  = s4[ln];
      end else begin
        e.d32 = '0; e.s32 = 1'b0; e.d4 = '0; e.s4 = 1'b0;
      end
      sb.push_back(e);
    end
    for (int k = 0; k < NL; k++) begin
      pop = $countones(recv[k*NB +: NB] ^ calc[k*NB +: NB]);
      acc = en && am_m[k] && !cl;
      if (cl) begin
        m32[k] = 0; s32[k] = 0; m4[k] = 0; s4[k] = 0;
      end else if (rq && rc && (ln == k)) begin
        m32[k] = acc ? pop : 0;
        s32[k] = 0;
        m4[k]  = acc ? ((pop > MAX4) ? MAX4 : pop) : 0;
        s4[k]  = acc && (pop > MAX4);
      end else if (acc) begin
        s = m32[k] + pop;
        if (s > MAX32) begin m32[k] = MAX32; s32[k] = 1; end else m32[k] = s;
        s = m4[k] + pop;
        if (s > MAX4) begin m4[k] = MAX4; s4[k] = 1; end else m4[k] = s;
      end
    end
    @(posedge clk);
    #1;
    am = '0; rd_req = 1'b0; rd_clear = 1'b0; clr = 1'b0;
  endtask

  // Read responses are compared on the falling edge of their due cycle.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      check("rd_valid32", vld_a, 1'b1);
      check("rd_valid4",  vld_b, 1'b1);
      check("rd_data32",  data_a, mon_e.d32);
      check("rd_sat32",   sat_a, mon_e.s32);
      check("rd_data4",   data_b, mon_e.d4);
      check("rd_sat4",    sat_b, mon_e.s4);
      check("rd_err32",   err_a, mon_e.err);
      check("rd_err4",    err_b, mon_e.err);
    end else if (vld_a || vld_b) begin
      check("rd_spurious", {vld_a, vld_b}, 2'b00);
    end
  end

  initial begin
    logic [7:0] r;
    rst = 1'b1; en = 1'b0; clr = 1'b0; rd_req = 1'b0; rd_clear = 1'b0;
    am = '0; recv = '0; calc = '0; wlen = '0; thr = '0; rd_lane = '0;
    for (int k = 0; k < NL; k++) begin m32[k] = 0; m4[k] = 0; s32[k] = 0; s4[k] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_vld",   {vld_a, vld_b}, 2'b00);
    check("reset_data",  {data_a, data_b}, 36'd0);
    check("reset_flags", {sat_a, err_a, sat_b, err_b}, 4'd0);
    check("reset_alarm", {alarm_a, alarm_b}, 40'd0);

    // Matching BIPs on every lane never count.
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < NL; k++) begin r = 8'($urandom); set_lane(k, r, r); end
      step('1);
    end
    for (int k = 0; k < NL; k++) step('0, 1'b1, 5'(k));
    @(negedge clk);
    check("clean_alarm", alarm_a, '0);

    // Lane 3, all eight bits wrong.
    recv = '0; calc = '0;
    set_lane(3, 8'hFF, 8'h00);
    step(NL'(1) << 3);
    step('0, 1'b1, 5'd3);

    // Saturation on the 4-bit instance; the 32-bit instance keeps counting.
    step('0, 1'b0, 5'd0, 1'b0, 1'b1);
    recv = '0; calc = '0;
    set_lane(0, 8'hFF, 8'h00);
    step(NL'(1));
    step(NL'(1));
    step('0, 1'b1, 5'd0);
    step(NL'(1));
    step(NL'(1), 1'b1, 5'd0);
    step('0, 1'b1, 5'd0);

    // Clear-on-read with a same-cycle event on lane 5.
    recv = '0; calc = '0;
    set_lane(5, 8'h07, 8'h00);
    step(NL'(1) << 5);
    step(NL'(1) << 5);
    step(NL'(1) << 5, 1'b1, 5'd5, 1'b1);
    step('0, 1'b1, 5'd5);
    step('0, 1'b1, 5'd0, 1'b1);
    step('0, 1'b1, 5'd0);

    // Windowed alarm on lane 1.
    step('0, 1'b0, 5'd0, 1'b0, 1'b1);
    recv = '0; calc = '0;
    wlen = 8'd4; thr = 8'd5;
    for (int i = 0; i < 4; i++) begin set_lane(1, ones(1), 8'h00); step(NL'(1) << 1); end
    @(negedge clk);
    check("win_low_alarm", alarm_a[1], 1'b0);
    set_lane(1, ones(2), 8'h00); step(NL'(1) << 1);
    set_lane(1, ones(2), 8'h00); step(NL'(1) << 1);
    set_lane(1, ones(0), 8'h00); step(NL'(1) << 1);
    @(negedge clk);
    check("win_mid_alarm", alarm_a[1], 1'b0);
    set_lane(1, ones(1), 8'h00); step(NL'(1) << 1);
    @(negedge clk);
    check("win_high_alarm", alarm_a, NL'(1) << 1);
    check("win_high_alarm4", alarm_b, NL'(1) << 1);
    wlen = 8'd0;
    step('0);
    @(negedge clk);
    check("win_off_alarm", alarm_a, '0);

    // Enable low: events ignored, reads still serviced.
    en = 1'b0;
    recv = '0; calc = '0;
    set_lane(2, 8'hFF, 8'h00);
    step(NL'(1) << 2);
    step('0, 1'b1, 5'd2);
    en = 1'b1;

    // Out-of-range lanes.
    step('0, 1'b1, 5'd20);
    step('0, 1'b1, 5'd31, 1'b1);

    // Global clear beats same-cycle events and the read-clear, read sees old value.
    wlen = 8'd1; thr = 8'd1;
    recv = '0; calc = '0;
    set_lane(7, 8'h0F, 8'h00);
    step(NL'(1) << 7);
    @(negedge clk);
    check("alarm_single", alarm_a, NL'(1) << 7);
    for (int k = 0; k < NL; k++) set_lane(k, 8'hFF, 8'h00);
    step('1, 1'b1, 5'd7, 1'b1, 1'b1);
    @(negedge clk);
    check("clear_alarm", alarm_a, '0);
    for (int k = 0; k < NL; k++) step('0, 1'b1, 5'(k));
    wlen = 8'd0;

    // Random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      en = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NL; k++) set_lane(k, 8'($urandom), 8'($urandom));
      step(NL'($urandom), 1'($urandom), 5'($urandom_range(0, 21)),
           1'($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
    end
    en = 1'b1;
    for (int k = 0; k < NL; k++) step('0, 1'b1, 5'(k));
    repeat (3) step('0);
    check("sb_drain", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
